// File: rtl/ahb_sram_slave.sv
`timescale 1ns/1ps
// ahb_sram_slave: AHB-Lite subordinate wrapping a single-port word SRAM.
// Answers single transfers with optional wait states and byte/half/word writes.
// Optional feature macro: AHB_SRAM_SLAVE_ERR_EN (out-of-range, oversize or
// misaligned transfers get a two-cycle ERROR response). When the macro is not
// defined, the slave never errors. Addresses alias modulo MEM_SIZE, sizes above
// a word are treated as a word, and address bits below the access size read as 0.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hready_in
//                   address-phase inputs (hburst/hprot ignored)
//   hwdata          write data, sampled in the completing data cycle
//   hreadyout       data-phase completion (low during wait/first error cycle)
//   hresp           0 OKAY, 1 ERROR
//   hrdata          full read word in a read data cycle, otherwise 0
module ahb_sram_slave #(
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned ADDR_LENGTH = 32,
    parameter int unsigned MEM_SIZE    = 4096,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hsel,
    input  logic [ADDR_LENGTH-1:0] haddr,
    input  logic [1:0]             htrans,
    input  logic                   hwrite,
    input  logic [2:0]             hsize,
    input  logic [2:0]             hburst,
    input  logic [3:0]             hprot,
    input  logic [WORD_SIZE-1:0]   hwdata,
    input  logic                   hready_in,
    output logic                   hreadyout,
    output logic                   hresp,
    output logic [WORD_SIZE-1:0]   hrdata
);

    localparam int unsigned AW    = $clog2(MEM_SIZE);
    localparam int unsigned IDX_W = AW - 2;
    localparam int unsigned DEPTH = MEM_SIZE / 4;
    localparam int unsigned NB    = WORD_SIZE / 8;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic                 write_q, write_d;
    logic [1:0]           size_q, size_d;
    logic                 hreadyout_q, hreadyout_d;
    logic                 hresp_q, hresp_d;
    logic [WORD_SIZE-1:0] hrdata_q, hrdata_d;

    logic [WORD_SIZE-1:0] mem_q [DEPTH];

    logic                 accept_c;
    logic                 err_c;
    logic                 commit_c;
    logic [1:0]           size_n_c;
    logic [AW-1:0]        addr_n_c;
    logic [NB-1:0]        be_c;
    logic [WORD_SIZE-1:0] wr_word_c;
    logic [IDX_W-1:0]     idx_q_c;
    logic                 unused_c;

    assign accept_c = hsel & htrans[1] & hready_in;
    assign idx_q_c  = addr_q[AW-1:2];
    assign commit_c = (state_q == ST_DATA) & write_q & ~rst;
    assign unused_c = ^{hburst, hprot, htrans[0], haddr};

`ifdef AHB_SRAM_SLAVE_ERR_EN
    localparam logic [ADDR_LENGTH:0] MEM_LIMIT = (ADDR_LENGTH+1)'(MEM_SIZE);

    // Out of range, larger than a word, or not aligned to the access size.
    assign err_c = ({1'b0, haddr} >= MEM_LIMIT)
                 | (hsize > 3'd2)
                 | ((hsize == 3'd1) & haddr[0])
                 | ((hsize == 3'd2) & (|haddr[1:0]));
`else
    assign err_c = 1'b0;
`endif

    // Normalised size/address captured for the data phase.
    always_comb begin
        size_n_c = (hsize > 3'd2) ? 2'd2 : hsize[1:0];
        addr_n_c = haddr[AW-1:0];
        if (size_n_c == 2'd1) begin
            addr_n_c[0] = 1'b0;
        end else if (size_n_c == 2'd2) begin
            addr_n_c[1:0] = 2'b00;
        end
    end

    // Byte-lane enables and merged write word for the current data phase.
    always_comb begin
        be_c      = '1;
        wr_word_c = mem_q[idx_q_c];
        case (size_q)
            2'd0:    be_c = NB'(1) << addr_q[1:0];
            2'd1:    be_c = NB'(3) << {addr_q[1], 1'b0};
            default: be_c = '1;
        endcase
        for (int unsigned b = 0; b < NB; b++) begin
            if (be_c[b]) begin
                wr_word_c[b*8 +: 8] = hwdata[b*8 +: 8];
            end
        end
    end

    // Next state and registered-output values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        write_d     = write_q;
        size_d      = size_q;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        hrdata_d    = '0;

        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: state_d = ST_IDLE;
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        // New transfers are only seen while the bus is ready (never in WAIT/ERR1).
        if (accept_c && (state_q == ST_IDLE || state_q == ST_DATA || state_q == ST_ERR2)) begin
            addr_d  = addr_n_c;
            write_d = hwrite;
            size_d  = size_n_c;
            if (err_c) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES != 0) begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(WAIT_STATES);
            end else begin
                state_d = ST_DATA;
            end
        end

        hreadyout_d = !(state_d == ST_WAIT || state_d == ST_ERR1);
        hresp_d     = (state_d == ST_ERR1 || state_d == ST_ERR2);

        // Read data; forward a same-word write committing this cycle.
        if (state_d == ST_DATA && !write_d) begin
            hrdata_d = mem_q[addr_d[AW-1:2]];
            if (commit_c && (addr_d[AW-1:2] == idx_q_c)) begin
                hrdata_d = wr_word_c;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= 2'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit_c) begin
            mem_q[idx_q_c] <= wr_word_c;
        end
    end

    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;
    assign hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
`timescale 1ns/1ps
// Bench for ahb_sram_slave: two instances (0 and 3 wait states) driven by a
// pipelined AHB master, checked against a byte-array memory model.
module tb_ahb_sram_slave;

    localparam int unsigned MEM_SIZE = 4096;
    localparam int unsigned NDUT     = 2;
    localparam int unsigned WS0      = 0;
    localparam int unsigned WS1      = 3;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          gap;
        logic        chk;
        logic [31:0] exp;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hsel      [NDUT];
    logic [31:0] haddr     [NDUT];
    logic [1:0]  htrans    [NDUT];
    logic        hwrite    [NDUT];
    logic [2:0]  hsize     [NDUT];
    logic [31:0] hwdata    [NDUT];
    logic        hreadyout [NDUT];
    logic        hresp     [NDUT];
    logic [31:0] hrdata    [NDUT];

    logic [7:0]  ref_mem [NDUT][MEM_SIZE];
    op_t         ops[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    ahb_sram_slave #(.WORD_SIZE(32), .ADDR_LENGTH(32), .MEM_SIZE(MEM_SIZE), .WAIT_STATES(WS0)) dut0 (
        .clk(clk), .rst(rst), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]),
        .hwrite(hwrite[0]), .hsize(hsize[0]), .hburst(hburst), .hprot(hprot),
        .hwdata(hwdata[0]), .hready_in(hreadyout[0]), .hreadyout(hreadyout[0]),
        .hresp(hresp[0]), .hrdata(hrdata[0])
    );

    ahb_sram_slave #(.WORD_SIZE(32), .ADDR_LENGTH(32), .MEM_SIZE(MEM_SIZE), .WAIT_STATES(WS1)) dut1 (
        .clk(clk), .rst(rst), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]),
        .hwrite(hwrite[1]), .hsize(hsize[1]), .hburst(hburst), .hprot(hprot),
        .hwdata(hwdata[1]), .hready_in(hreadyout[1]), .hreadyout(hreadyout[1]),
        .hresp(hresp[1]), .hrdata(hrdata[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? int'(WS0) : int'(WS1);
    endfunction

    function automatic int unsigned nbytes(input logic [2:0] size);
        return (size > 3'd2) ? 4 : (1 << size);
    endfunction

    function automatic bit is_err(input op_t o);
`ifdef AHB_SRAM_SLAVE_ERR_EN
        return (o.addr >= MEM_SIZE) || (o.size > 3'd2) || ((o.addr % nbytes(o.size)) != 0);
`else
        return (o.addr === 32'hFFFF_FFFF) && (o.size === 3'bxxx);
`endif
    endfunction

    // Full word containing the (aliased) address, little-endian lanes.
    function automatic logic [31:0] ref_read(input int d, input logic [31:0] a);
        int unsigned base;
        logic [31:0] w;
        base = (a % MEM_SIZE) & ~32'd3;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[d][base + k];
        return w;
    endfunction

    // Bytes covered by the access (aligned down to its size) take their lane of wdata.
    task automatic ref_write(input int d, input op_t o);
        int unsigned nb;
        int unsigned base;
        nb   = nbytes(o.size);
        base = (o.addr % MEM_SIZE) & ~(nb - 1);
        for (int unsigned k = 0; k < nb; k++) begin
            ref_mem[d][base + k] = o.wdata[8*((base + k) % 4) +: 8];
        end
    endtask

    function automatic op_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata, input int gap,
                               input logic chk, input logic [31:0] exp);
        op_t o;
        o.wr = wr; o.addr = addr; o.size = size; o.wdata = wdata;
        o.gap = gap; o.chk = chk; o.exp = exp;
        return o;
    endfunction

    task automatic drive_idle(input int d);
        case ($urandom_range(0, 2))
            0:       begin hsel[d] = 1'b0; htrans[d] = 2'($urandom()); end
            1:       begin hsel[d] = 1'b1; htrans[d] = {1'b0, 1'($urandom())}; end
            default: begin hsel[d] = 1'b0; htrans[d] = 2'b10; end
        endcase
        haddr[d]  = $urandom();
        hwrite[d] = 1'($urandom());
        hsize[d]  = 3'($urandom());
    endtask

    task automatic drive_addr(input int d, input op_t o);
        hsel[d]   = 1'b1;
        htrans[d] = 2'b10;
        haddr[d]  = o.addr;
        hwrite[d] = o.wr;
        hsize[d]  = o.size;
    endtask

    // Pipelined master: runs every queued op on instance d, checking each cycle.
    task automatic run_ops(input int d);
        op_t cur, nx;
        bit  cur_v, nx_v, rdy, e, first_resp;
        int  gap, low_cnt, exp_low, cyc, limit;
        logic [31:0] exp_rd;
        cur_v = 0; nx_v = 0; gap = 0; low_cnt = 0; first_resp = 0; cyc = 0;
        limit = 30 * ops.size() + 50;
        while (ops.size() > 0 || nx_v || cur_v) begin
            cyc++;
            if (cyc > limit) begin
                check_eq("timeout", 32'(cyc), 32'(limit));
                ops.delete();
                drive_idle(d);
                return;
            end
            if (!nx_v && ops.size() > 0) begin
                nx = ops.pop_front(); nx_v = 1; gap = nx.gap;
            end
            if (nx_v && gap == 0) drive_addr(d, nx);
            else                  drive_idle(d);
            hwdata[d] = (cur_v && cur.wr && hreadyout[d]) ? cur.wdata : $urandom();
            hburst    = 3'($urandom());
            hprot     = 4'($urandom());
            @(negedge clk);
            rdy = hreadyout[d];
            if (cur_v) begin
                e       = is_err(cur);
                exp_low = e ? 1 : ws_of(d);
                if (!rdy) begin
                    if (low_cnt == 0) first_resp = hresp[d];
                    low_cnt++;
                    check_eq("wait_rdata", hrdata[d], 32'h0);
                    if (low_cnt > 20) begin
                        check_eq("stall", 32'(low_cnt), 32'(exp_low));
                        ops.delete();
                        drive_idle(d);
                        return;
                    end
                end else begin
                    check_eq($sformatf("d%0d_wait_cycles", d), 32'(low_cnt), 32'(exp_low));
                    check_eq("resp", 32'(hresp[d]), 32'(e));
                    if (e) check_eq("err_first_resp", 32'(first_resp), 32'h1);
                    if (cur.wr) begin
                        check_eq("wr_rdata", hrdata[d], 32'h0);
                        if (!e) ref_write(d, cur);
                    end else begin
                        exp_rd = e ? 32'h0 : ref_read(d, cur.addr);
                        check_eq($sformatf("d%0d_rdata@%h", d, cur.addr), hrdata[d], exp_rd);
                        if (cur.chk) check_eq("rdata_lit", hrdata[d], cur.exp);
                    end
                end
            end else begin
                check_eq("idle_ready", 32'(rdy), 32'h1);
                check_eq("idle_resp", 32'(hresp[d]), 32'h0);
                check_eq("idle_rdata", hrdata[d], 32'h0);
            end
            @(posedge clk); #1;
            if (rdy) begin
                cur_v = 0;
                if (nx_v && gap == 0) begin
                    cur = nx; cur_v = 1; nx_v = 0; low_cnt = 0;
                end else if (nx_v) begin
                    gap--;
                end
            end
        end
        drive_idle(d);
    endtask

    task automatic gen_random(input int n);
        logic [31:0] a;
        logic [2:0]  s;
        int          r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      a = $urandom_range(0, 63);
            else if (r < 9) a = $urandom_range(0, MEM_SIZE - 1);
            else            a = $urandom();
            s = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            ops.push_back(mk(1'($urandom()), a, s, $urandom(),
                             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, 1'b0, 32'h0));
        end
    endtask

    initial begin
        logic [31:0] keep8;
        rst = 1'b1;
        hburst = '0; hprot = '0;
        for (int d = 0; d < NDUT; d++) begin
            drive_idle(d);
            hwdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check_eq("rst_ready", 32'(hreadyout[d]), 32'h1);
            check_eq("rst_resp", 32'(hresp[d]), 32'h0);
            check_eq("rst_rdata", hrdata[d], 32'h0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Preload every word so all later reads are defined.
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < int'(MEM_SIZE / 4); i++)
                ops.push_back(mk(1'b1, 32'(i * 4), 3'd2, $urandom(), 0, 1'b0, 32'h0));
            run_ops(d);
        end

        for (int d = 0; d < NDUT; d++) begin
            // Word write then read, plus a plain read.
            ops.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 1'b0, 32'h0));
            ops.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0, 1, 1'b1, 32'hDEADBEEF));
            ops.push_back(mk(1'b0, 32'h20, 3'd2, 32'h0, 1, 1'b0, 32'h0));
            // Byte and half merges.
            ops.push_back(mk(1'b1, 32'h10, 3'd2, 32'h11223344, 0, 1'b0, 32'h0));
            ops.push_back(mk(1'b1, 32'h11, 3'd0, 32'h0000AA00, 0, 1'b0, 32'h0));
            ops.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0, 0, 1'b1, 32'h1122AA44));
            ops.push_back(mk(1'b1, 32'h12, 3'd1, 32'hBEEF0000, 0, 1'b0, 32'h0));
            ops.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0, 0, 1'b1, 32'hBEEFAA44));
            // Back-to-back write then read of the same word.
            ops.push_back(mk(1'b1, 32'h40, 3'd2, 32'h5, 1, 1'b0, 32'h0));
            ops.push_back(mk(1'b0, 32'h40, 3'd2, 32'h0, 0, 1'b1, 32'h5));
            // Out-of-range read: aliases to 0x0, or errors.
            ops.push_back(mk(1'b1, 32'h0, 3'd2, 32'hCAFEF00D, 0, 1'b0, 32'h0));
`ifdef AHB_SRAM_SLAVE_ERR_EN
            ops.push_back(mk(1'b0, 32'h1000, 3'd2, 32'h0, 0, 1'b0, 32'h0));
`else
            ops.push_back(mk(1'b0, 32'h1000, 3'd2, 32'h0, 0, 1'b1, 32'hCAFEF00D));
`endif
            run_ops(d);
        end

        // Reset during the wait states of a write to 0x8.
        keep8 = ref_read(1, 32'h8);
        drive_idle(0);
        hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1;
        haddr[1] = 32'h8; hsize[1] = 3'd2; hwdata[1] = $urandom();
        @(posedge clk); #1;
        drive_idle(1);
        hsel[1] = 1'b0;
        hwdata[1] = 32'h77;
        check_eq("t6_wait1", 32'(hreadyout[1]), 32'h0);
        @(posedge clk); #1;
        check_eq("t6_wait2", 32'(hreadyout[1]), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("t6_ready", 32'(hreadyout[1]), 32'h1);
        check_eq("t6_resp", 32'(hresp[1]), 32'h0);
        check_eq("t6_rdata", hrdata[1], 32'h0);
        ops.push_back(mk(1'b0, 32'h8, 3'd2, 32'h0, 0, 1'b1, keep8));
        run_ops(1);

        // Randomized mixed traffic.
        for (int d = 0; d < NDUT; d++) begin
            gen_random(300);
            run_ops(d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
